// File: rtl/hms_timekeeper.sv
// hms_timekeeper: seconds/minutes/hours timekeeping datapath.
// Conditions the controller's advance strobes into single-cycle ticks, keeps
// the three counters, returns per-field wrap pulses, and presents registered
// BCD digits to the display stage.
// Optional feature: define HMS_TIMEKEEPER_BLINK_EN to blink the field selected
// by i_position while in setup mode. Without it, o_blank is constant 3'b000.
module hms_timekeeper #(
    parameter int SEC_MAX    = 60,
    parameter int MIN_MAX    = 60,
    parameter int HOUR_MAX   = 24,
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode,
    input  logic [1:0] i_position,
    input  logic       i_sec_clk,
    input  logic       i_min_clk,
    input  logic       i_hour_clk,
    output logic       o_max_hit_sec,
    output logic       o_max_hit_min,
    output logic       o_max_hit_hour,
    output logic [7:0] o_sec_bcd,
    output logic [7:0] o_min_bcd,
    output logic [7:0] o_hour_bcd,
    output logic [2:0] o_blank
);

    localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX - 1);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX - 1);

    // Per strobe: bit 0 = s1, bit 1 = s2 (synchronised), bit 2 = s3 (history)
    logic [2:0] sec_sync, min_sync, hour_sync;
    logic       sec_tick, min_tick, hour_tick;

    logic [5:0] sec_cnt, min_cnt;
    logic [4:0] hour_cnt;

    // Two-flop synchronisers plus history flop for rising-edge detection.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; the reset branch is asynchronous to match rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_sync  <= 3'b000;
            min_sync  <= 3'b000;
            hour_sync <= 3'b000;
        end else begin
            sec_sync  <= {sec_sync[1:0],  i_sec_clk};
            min_sync  <= {min_sync[1:0],  i_min_clk};
            hour_sync <= {hour_sync[1:0], i_hour_clk};
        end
    end

    // A held-high strobe produces one tick; it must drop to re-arm.
    assign sec_tick  = sec_sync[1]  & ~sec_sync[2];
    assign min_tick  = min_sync[1]  & ~min_sync[2];
    assign hour_tick = hour_sync[1] & ~hour_sync[2];

    // Counters and their wrap pulses. ">=" also folds unreachable values back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt        <= '0;
            min_cnt        <= '0;
            hour_cnt       <= '0;
            o_max_hit_sec  <= 1'b0;
            o_max_hit_min  <= 1'b0;
            o_max_hit_hour <= 1'b0;
        end else begin
            o_max_hit_sec  <= sec_tick  && (sec_cnt  >= SEC_LAST);
            o_max_hit_min  <= min_tick  && (min_cnt  >= MIN_LAST);
            o_max_hit_hour <= hour_tick && (hour_cnt >= HOUR_LAST);
            if (sec_tick)
                sec_cnt <= (sec_cnt >= SEC_LAST) ? 6'd0 : sec_cnt + 6'd1;
            if (min_tick)
                min_cnt <= (min_cnt >= MIN_LAST) ? 6'd0 : min_cnt + 6'd1;
            if (hour_tick)
                hour_cnt <= (hour_cnt >= HOUR_LAST) ? 5'd0 : hour_cnt + 5'd1;
        end
    end

    // Binary 0..63 to {tens, ones} via a compare chain instead of a divider.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 6'd60) begin
            tens = 4'd6; ones = 4'(v - 6'd60);
        end else if (v >= 6'd50) begin
            tens = 4'd5; ones = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            tens = 4'd4; ones = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            tens = 4'd3; ones = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            tens = 4'd2; ones = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            tens = 4'd1; ones = 4'(v - 6'd10);
        end else begin
            tens = 4'd0; ones = v[3:0];
        end
        return {tens, ones};
    endfunction

    // Display digits, registered one cycle behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sec_bcd  <= 8'h00;
            o_min_bcd  <= 8'h00;
            o_hour_bcd <= 8'h00;
        end else begin
            o_sec_bcd  <= to_bcd(sec_cnt);
            o_min_bcd  <= to_bcd(min_cnt);
            o_hour_bcd <= to_bcd({1'b0, hour_cnt});
        end
    end

`ifdef HMS_TIMEKEEPER_BLINK_EN
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               sel_tick;

    // Tick of the field being adjusted; position 3 behaves as seconds.
    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        sel_tick = sec_tick;
        case (i_position)
            2'd1:    sel_tick = min_tick;
            2'd2:    sel_tick = hour_tick;
            default: sel_tick = sec_tick;
        endcase
    end

    // Blink timebase: idle at 0 in clock mode, restarted visible on adjust.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!i_mode || sel_tick) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Blank only the selected field, only in setup mode.
    always_comb begin
        o_blank = 3'b000;
        if (i_mode) begin
            case (i_position)
                2'd1:    o_blank[1] = blink_phase;
                2'd2:    o_blank[2] = blink_phase;
                default: o_blank[0] = blink_phase;
            endcase
        end
    end
`else
    // Blink disabled: mode, position and BLINK_HALF have no effect.
    logic unused_blink;
    assign unused_blink = ^{i_mode, i_position, (BLINK_HALF != 0)};
    assign o_blank      = 3'b000;
`endif

endmodule

// File: doc/hms_timekeeper.md
Name: hms_timekeeper

Overview:
- Time-keeping datapath directly downstream of the clock controller.
- Consumes the controller's sec/min/hour advance strobes, mode and position.
- Maintains seconds, minutes and hours counters and returns per-field max-hit carry pulses to the controller.
- Presents registered BCD digits to the 7-segment display stage.

Parameters:
- SEC_MAX, 60, modulus of seconds counter
- MIN_MAX, 60, modulus of minutes counter
- HOUR_MAX, 24, modulus of hours counter
- BLINK_HALF, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz); used only with BLINK_EN

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- i_mode  in  1  0 = clock mode, 1 = setup mode
- i_position  in  2  0 = sec, 1 = min, 2 = hour (3 treated as sec)
- i_sec_clk  in  1  seconds advance strobe from controller (level; rising edge counts)
- i_min_clk  in  1  minutes advance strobe
- i_hour_clk  in  1  hours advance strobe
- o_max_hit_sec  out  1  one-cycle pulse on sec wrap
- o_max_hit_min  out  1  one-cycle pulse on min wrap
- o_max_hit_hour  out  1  one-cycle pulse on hour wrap
- o_sec_bcd  out  8  {tens, ones} BCD seconds
- o_min_bcd  out  8  {tens, ones} BCD minutes
- o_hour_bcd  out  8  {tens, ones} BCD hours
- o_blank  out  3  per-field display blank {hour, min, sec}

Behaviour:
- Reset (async, rst_n=0): all counters 0, all sync/edge flops 0, all max_hit 0, all BCD outputs 8'h00, o_blank 3'b000, blink counter 0, blink phase 0.
- Input conditioning, per strobe:
  - Two-flop synchroniser s1, s2, plus history flop s3.
  - tick = s2 & ~s3.
  - Rising input first sampled high at edge N → s2 high at N+1 → counter updates at edge N+2.
  - Held-high input yields exactly one tick; input must be low ≥1 cycle to re-arm.
- Counters, each independent, 6-bit sec/min, 5-bit hour:
  - On tick: if count == MAX-1, count ← 0, else count ← count+1.
  - No tick: hold.
- Max-hit:
  - o_max_hit_x registered; high for exactly the one cycle following the edge where that counter wraps MAX-1 → 0; otherwise 0.
  - Produced in both modes. The controller decides routing; this block does not gate on mode.
- Carry chain in clock mode (controller feeds max_hit back as next strobe):
  - 59 s → 0 s wrap increments minutes 3 edges later (1 pulse cycle + 2 sync).
  - 23:59:59 + tick → 00:00:00 with three staggered wrap pulses.
- Simultaneous ticks on different counters in the same cycle: each counter updates independently.
- BCD conversion:
  - tens = count/10, ones = count%10.
  - Registered one cycle after the counter update; no division logic wider than needed.
- i_position == 3: treated as sec for blink selection only.
- Reset mid-operation: asynchronous; all state clears immediately. In-flight ticks are lost. First post-reset tick requires a fresh rising edge.
- Max values are never exceeded. Counter values ≥ MAX (not reachable) wrap to 0 on the next tick.

Optional Feature:
- Macro: HMS_TIMEKEEPER_BLINK_EN.
- With it defined:
  - Free-running counter 0..BLINK_HALF-1 toggles a blink phase on wrap.
  - In setup mode (i_mode=1), o_blank bit for the selected field equals the blink phase; other bits 0.
  - In clock mode, o_blank = 0, and the counter and phase are reset to 0 so every setup entry starts visible.
  - Any tick on the selected field forces phase to 0 and restarts the counter (digit visible while adjusting).
- Without it: o_blank tied to 3'b000; no blink counter synthesised; BLINK_HALF unused.

Test Plan:
- Reset release, then one i_sec_clk rising edge → o_sec_bcd 8'h00 → 8'h01. Counter changes at the 2nd edge after first high sample; BCD follows 1 cycle later.
- Preload sec to 59 via 59 ticks, then tick again → o_sec_bcd 8'h00, and o_max_hit_sec high for exactly 1 cycle.
- Drive to 23:59:59, loop max_hit_sec→i_min_clk and max_hit_min→i_hour_clk externally, then sec tick → 00:00:00. o_max_hit_hour pulses once; no other spurious pulses.
- Hold i_min_clk high for 100 cycles → minutes increment by exactly 1. Glitch low for 1 cycle then high → second increment.
- Assert rst_n low mid-carry at 00:59:59 during the min pulse → all outputs 0 immediately, with no increment after release.
- With HMS_TIMEKEEPER_BLINK_EN and BLINK_HALF=4:
  - i_mode=1, i_position=1 → o_blank toggles 3'b000/3'b010 every 4 cycles.
  - An i_min_clk tick forces 3'b000.
  - i_mode=0 → 3'b000.
